// File: rtl/alu_issue_if.sv
// Handshake bundle between the ALU issue stage, its upstream decoder and the ALU.
// The upstream and ALU sides use the master modport; the issue stage uses the slave modport.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1_val;
    logic [XLEN-1:0] in_rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [3:0]      out_op;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            wb_valid;
    logic [4:0]      wb_rd;

    modport master (
        output in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_rd, out_illegal, wb_valid, wb_rd
    );

    modport slave (
        input  in_valid, in_instr, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_rd, out_illegal, wb_valid, wb_rd
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM issue stage: decodes on acceptance into a 2-entry skid buffer
// and presents the oldest entry to the ALU, with a one-cycle-late writeback tag.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd2, OP_SLTU = 4'd3, OP_XOR = 4'd4,
        OP_OR   = 4'd5, OP_AND = 4'd6, OP_SLL = 4'd7, OP_SRL  = 4'd8, OP_SRA = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_e         op;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            is_op;
    logic            is_imm;
    logic            is_shift;
    logic            alt;
    logic            legal;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm_sext;
    alu_op_e         op_sel;
    entry_t          in_dec;
    logic            unused_rs1_field;

    state_e state_q;
    entry_t head_q;
    entry_t tail_q;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   wb_valid_q;
    logic   [4:0] wb_rd_q;
    logic   accept;
    logic   fire;

    assign opcode           = bus.in_instr[6:0];
    assign funct3           = bus.in_instr[14:12];
    assign funct7           = bus.in_instr[31:25];
    assign unused_rs1_field = ^bus.in_instr[19:15];
    assign is_op            = (opcode == OPC_OP);
    assign is_imm           = (opcode == OPC_OP_IMM);
    assign is_shift         = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign alt              = (funct7 == F7_ALT);
    assign shamt            = is_op ? bus.in_rs2_val[4:0] : bus.in_instr[24:20];
    assign imm_sext         = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        op_sel = OP_ADD;
        legal  = 1'b0;
        in_dec = '0;
        case (funct3)
            3'b000:  op_sel = (is_op && alt) ? OP_SUB : OP_ADD;
            3'b001:  op_sel = OP_SLL;
            3'b010:  op_sel = OP_SLT;
            3'b011:  op_sel = OP_SLTU;
            3'b100:  op_sel = OP_XOR;
            3'b101:  op_sel = alt ? OP_SRA : OP_SRL;
            3'b110:  op_sel = OP_OR;
            default: op_sel = OP_AND;
        endcase
        if (is_op) begin
            legal = (funct7 == F7_BASE) || (alt && (funct3 == 3'b000 || funct3 == 3'b101));
        end else if (is_imm) begin
            legal = !is_shift || (funct7 == F7_BASE) || (alt && funct3 == 3'b101);
        end
        // Illegal entries keep the all-zero default payload with only the flag set.
        if (legal) begin
            in_dec.a  = bus.in_rs1_val;
            in_dec.b  = is_shift ? {{(XLEN-5){1'b0}}, shamt} : (is_op ? bus.in_rs2_val : imm_sext);
            in_dec.op = op_sel;
            in_dec.rd = bus.in_instr[11:7];
        end else begin
            in_dec.illegal = 1'b1;
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign fire   = out_valid_q & bus.out_ready;

    // NOTE: both skid entries are reset, since the head drives the outputs directly and the tail
    // is promoted into the head; sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            if (fire && !head_q.illegal && head_q.rd != 5'd0) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= head_q.rd;
            end
            case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        head_q      <= in_dec;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        head_q <= in_dec;
                    end else if (accept) begin
                        tail_q     <= in_dec;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        head_q     <= tail_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_a       = head_q.a;
    assign bus.out_b       = head_q.b;
    assign bus.out_op      = head_q.op;
    assign bus.out_rd      = head_q.rd;
    assign bus.out_illegal = head_q.illegal;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand width (32 is the only supported value).
REQ-002 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  in  1  upstream instruction+operands valid.
REQ-005 SHALL have port: in_ready  out  1  stage can accept; transfer when in_valid&in_ready.
REQ-006 SHALL have port: in_instr  in  32  RV32I instruction word.
REQ-007 SHALL have ports: in_rs1_val, in_rs2_val  in  32  register-file read values.
REQ-008 SHALL have port: out_valid  out  1  decoded ALU request valid.
REQ-009 SHALL have port: out_ready  in  1  ALU side accepts; fire = out_valid&out_ready.
REQ-010 SHALL have ports: out_a, out_b  out  32  ALU operands a, b.
REQ-011 SHALL have port: out_op  out  4  ALU op select (0 add, 1 sub, 2 slt, 3 sltu, 4 xor, 5 or, 6 and, 7 sll, 8 srl, 9 sra).
REQ-012 SHALL have ports: out_rd  out  5  destination; out_illegal  out  1  undecodable instruction.
REQ-013 SHALL have ports: wb_valid  out  1, wb_rd  out  5  writeback tag aligned with the registered ALU result.

Function
REQ-014 SHALL decode opcode 0110011 (OP): funct3/funct7 000/0000000 add, 000/0100000 sub, 001/0000000 sll, 010 slt, 011 sltu, 100 xor, 101/0000000 srl, 101/0100000 sra, 110 or, 111 and; a=rs1, b=rs2.
REQ-015 SHALL decode opcode 0010011 (OP-IMM): same funct3 mapping, a=rs1, b=sign-extended instr[31:20]; no sub.
REQ-016 SHALL, for every shift (OP and OP-IMM), drive b = {27'b0, shamt}, shamt = rs2[4:0] or instr[24:20].
REQ-017 SHALL flag illegal: other opcodes, funct7 other than 0000000 (or 0100000 where sub/sra/srai); illegal entries carry out_op=0, out_a=0, out_b=0, out_rd=0, out_illegal=1.
REQ-018 SHALL decode at acceptance and store decoded fields in a 2-entry skid buffer; outputs driven from registers only.
REQ-019 SHALL implement states EMPTY, ONE, FULL: EMPTY+accept->ONE; ONE+accept+fire->ONE; ONE+accept only->FULL; ONE+fire only->EMPTY; FULL+fire->ONE; else hold.
REQ-020 SHALL drive in_ready=1 in EMPTY and ONE, 0 in FULL, registered (no combinational path from out_ready).
REQ-021 SHALL drive out_valid=1 in ONE and FULL; out_* present the oldest entry and stay stable while out_valid&!out_ready.
REQ-022 SHALL preserve order: FULL->ONE promotes the younger entry to the head on the fire edge.
REQ-023 SHALL latency: accept at edge N -> out_valid visible after edge N when EMPTY (1 cycle).
REQ-024 SHALL assert wb_valid for exactly one cycle after each fire edge of a legal entry with rd!=0; wb_rd = that rd; otherwise wb_valid=0, wb_rd holds.
REQ-025 SHALL treat simultaneous accept and fire in ONE as full throughput: one instruction per cycle sustained with out_ready=1.
REQ-026 SHALL ignore in_instr/in_rs*_val when not accepting; out_ready ignored when out_valid=0.

Reset
REQ-027 SHALL on rst=1, immediately and independent of clk: state EMPTY, out_valid=0, in_ready=1 after rst release edge, wb_valid=0, out_a/out_b=0, out_op=0, out_rd=0, out_illegal=0, wb_rd=0.
REQ-028 SHALL discard both buffered entries and any pending wb_valid on reset mid-operation; first accept after release behaves as from EMPTY.
REQ-029 SHALL drive in_ready=0 while rst=1.

Verification
REQ-030 SHALL cover: add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_op=0, a=5, b=7, rd=3; following cycle wb_valid=1, wb_rd=3.
REQ-031 SHALL cover: addi x4,x1,-1 (imm 0xFFF), rs1=10 -> b=0xFFFFFFFF, op=0; srai x5,x1,4 -> op=9, b=4; sll with rs2=0x23 -> b=3.
REQ-032 SHALL cover: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 after second; release out_ready -> entries emerge in order, then third accepted.
REQ-033 SHALL cover: instr 0x0000006F (JAL) -> out_illegal=1, op=0, a=b=0, wb_valid stays 0; add x0,x1,x2 -> wb_valid stays 0.
REQ-034 SHALL cover: rst asserted mid-cycle with FULL buffer -> out_valid drops without clock edge; after release, no stale entry or wb_valid appears.
REQ-035 SHALL cover: 100 random legal OP/OP-IMM instructions with random out_ready -> scoreboard matches order, operands, op, rd; no loss or duplication.
